duty_gen_multi: RTL

- Multi-channel, runtime-programmable duty-cycle clock generator; the parametrised successor of the fixed 60% duty-cycle generator.
- Each of NCH channels produces a divided output clock with its own programmable period and high time.
- Configuration is written through a simple write port into per-channel shadow registers. New settings take effect only at a period boundary, so outputs never glitch.
- Sits beside the system clock as a source of slow strobes and PWM-style clocks for the FSM assignment blocks.

---
 rtl/duty_gen_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/duty_gen_multi.sv
// Multi-channel programmable duty-cycle clock generator.
// Each channel divides clk by a runtime period with a runtime high time; updates apply on wrap.
module duty_gen_multi #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CW         = 8,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_ON     = 6,
    localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic [CW-1:0]  cfg_on,
    output logic           cfg_err,
    output logic [NCH-1:0] out_clk,
    output logic [NCH-1:0] period_done
);

    localparam logic [CW-1:0] DefPeriod = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] DefOn     = CW'(DEF_ON);

    logic cfg_ok;
    logic cfg_err_q, cfg_err_d;

    assign cfg_ok    = (32'(cfg_ch) < NCH) && (cfg_period >= CW'(2));
    assign cfg_err_d = cfg_we && !cfg_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] count_q, count_d;
        logic [CW-1:0] per_q, per_d;
        logic [CW-1:0] on_q, on_d;
        logic [CW-1:0] sh_per_q, sh_per_d;
        logic [CW-1:0] sh_on_q, sh_on_d;
        logic          pend_q, pend_d;
        logic          out_q, out_d;
        logic          done_q, done_d;
        logic          wr_hit;
        logic          wrap;
        logic          apply;

        assign wr_hit = cfg_we && cfg_ok && (32'(cfg_ch) == i);
        assign wrap   = (count_q == per_q - CW'(1));
        // A disabled channel has no period in flight, so a pending shadow can land at once.
        assign apply  = pend_q && (!en[i] || wrap);

        always_comb begin
            count_d  = count_q;
            per_d    = per_q;
            on_d     = on_q;
            sh_per_d = sh_per_q;
            sh_on_d  = sh_on_q;
            pend_d   = pend_q;
            out_d    = 1'b0;
            done_d   = 1'b0;

            if (en[i]) begin
                out_d = (count_q < on_q);
                if (wrap) begin
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end else begin
                count_d = '0;
            end

            if (apply) begin
                per_d  = sh_per_q;
                on_d   = sh_on_q;
                pend_d = 1'b0;
            end

            // A write on the wrap edge lands after the old shadow was consumed.
            if (wr_hit) begin
                sh_per_d = cfg_period;
                sh_on_d  = cfg_on;
                pend_d   = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                count_q  <= '0;
                per_q    <= DefPeriod;
                on_q     <= DefOn;
                sh_per_q <= DefPeriod;
                sh_on_q  <= DefOn;
                pend_q   <= 1'b0;
                out_q    <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                count_q  <= count_d;
                per_q    <= per_d;
                on_q     <= on_d;
                sh_per_q <= sh_per_d;
                sh_on_q  <= sh_on_d;
                pend_q   <= pend_d;
                out_q    <= out_d;
                done_q   <= done_d;
            end
        end

        assign out_clk[i]     = out_q;
        assign period_done[i] = done_q;
    end

endmodule
